// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: square numbering, cursor wrap helper, debouncer states.
// No timing of its own; used by the input front end and the board logic.
package ttt_pkg;

    localparam logic [7:0] NO_SQUARE  = 8'd0;
    localparam logic [7:0] SQUARE_1   = 8'd1;
    localparam logic [7:0] SQUARE_2   = 8'd2;
    localparam logic [7:0] SQUARE_3   = 8'd3;
    localparam logic [7:0] SQUARE_4   = 8'd4;
    localparam logic [7:0] SQUARE_5   = 8'd5;
    localparam logic [7:0] SQUARE_6   = 8'd6;
    localparam logic [7:0] SQUARE_7   = 8'd7;
    localparam logic [7:0] SQUARE_8   = 8'd8;
    localparam logic [7:0] SQUARE_9   = 8'd9;
    localparam logic [7:0] SQUARE_MIN = SQUARE_1;
    localparam logic [7:0] SQUARE_MAX = SQUARE_9;

    typedef enum logic [1:0] {
        DEB_FILL1,
        DEB_FILL2,
        DEB_INIT,
        DEB_RUN
    } deb_state_t;

    // NO_SQUARE enters the ring at SQUARE_1 going CW and at SQUARE_9 going CCW.
    function automatic logic [7:0] next_square(input logic [7:0] cur, input logic ccw);
        logic [7:0] nxt;
        nxt = NO_SQUARE;
        if (ccw) begin
            nxt = (cur <= SQUARE_MIN || cur > SQUARE_MAX) ? SQUARE_MAX : cur - 8'd1;
        end else begin
            nxt = (cur >= SQUARE_MAX) ? SQUARE_MIN : cur + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Synchronise + debounce one raw pin; level/rise change DEBOUNCE_CYCLES+2 edges after a held raw change.
// No backpressure: rise is a one-cycle pulse, suppressed until init_done.
module input_debounce
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic din_raw,
    output logic level,
    output logic rise,
    output logic init_done
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    deb_state_t       state;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din_raw;
            sync2 <= sync1;
        end
    end

    // The FILL states wait out the synchroniser so the init load sees a real sample.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= DEB_FILL1;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            rise <= 1'b0;
            case (state)
                DEB_FILL1: state <= DEB_FILL2;
                DEB_FILL2: state <= DEB_INIT;
                DEB_INIT: begin
                    if (cnt == CNT_LAST) begin
                        level     <= sync2;
                        cnt       <= '0;
                        init_done <= 1'b1;
                        state     <= DEB_RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DEB_RUN: begin
                    if (sync2 == level) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        level <= sync2;
                        rise  <= sync2;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= DEB_FILL1;
            endcase
        end
    end

endmodule

// File: rtl/rotary_cursor.sv
// Rotary switch + button front end: cursor square 0/1..9 and one-cycle select pulse, DEBOUNCE_CYCLES+3 edges after raw.
// No backpressure: steps and presses are applied as they are decoded.
module rotary_cursor
    import ttt_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rot_a,
    input  logic       rot_b,
    input  logic       rot_center,
    output logic [7:0] square_num,
    output logic       ROTCTR_debounce,
    output logic       ready
);

    logic a_level, a_rise, a_init;
    logic b_level, b_rise, b_init;
    logic c_level, c_rise, c_init;
    logic unused_edges;

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_a (
        .clk(clk), .clr(clr), .din_raw(rot_a),
        .level(a_level), .rise(a_rise), .init_done(a_init)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_b (
        .clk(clk), .clr(clr), .din_raw(rot_b),
        .level(b_level), .rise(b_rise), .init_done(b_init)
    );

    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_c (
        .clk(clk), .clr(clr), .din_raw(rot_center),
        .level(c_level), .rise(c_rise), .init_done(c_init)
    );

    // Only A's rising edge steps the cursor; the other edge/level outputs are unused here.
    assign unused_edges = a_level ^ b_rise ^ c_level;

    assign ready = a_init & b_init & c_init;

    // B's debounced level at the A rise gives direction: 0 = CW, 1 = CCW.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            square_num      <= NO_SQUARE;
            ROTCTR_debounce <= 1'b0;
        end else begin
            ROTCTR_debounce <= ready & c_rise;
            if (ready && a_rise) begin
                square_num <= next_square(square_num, b_level);
            end
        end
    end

endmodule
